addsub_seq: RTL and testbench
=============================

// Module: addsub_seq
// PURPOSE
//  Parametrised, multi-cycle add/subtract unit; successor to the 8-bit ripple adder.
//  Processes WIDTH-bit operands CHUNK bits per clock with a registered inter-chunk carry,
//  trading latency for a short critical path.
//  Sits on the datapath behind valid/ready handshakes; one operation in flight at a time.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; must be a multiple of CHUNK
//  CHUNK    8  bits added per cycle; 1 <= CHUNK <= WIDTH; NCHUNK = WIDTH/CHUNK
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands/op valid
//  in_ready   out  1      unit can accept an operation
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (add) / borrow-in (sub)
//  op_sub     in   1      0: sum=a+b+cin; 1: sum=a-b-cin
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result, modulo 2^WIDTH
//  carry      out  1      add: carry-out; sub: NOT borrow-out (1 = no borrow)
//  overflow   out  1      two's-complement signed overflow
// BEHAVIOUR
//  - Reset (rst_n low, async): state IDLE; in_ready=0, out_valid=0, sum=0, carry=0,
//    overflow=0, chunk counter=0. in_ready rises on the first clk edge after rst_n high.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: in_ready=1. Accept on in_valid&&in_ready: latch a, b_eff = op_sub ? ~b : b,
//    carry register = op_sub ? ~cin : cin; latch a[MSB], b_eff[MSB]; counter=0; go RUN.
//  - RUN: in_ready=0. Each cycle add chunk k (bits k*CHUNK+:CHUNK) with carry register;
//    write result chunk, update carry register; counter++. After chunk NCHUNK-1 go DONE.
//  - DONE: out_valid=1; sum, carry, overflow stable until out_ready. On out_valid&&out_ready
//    go IDLE; in_ready reasserts the next cycle (no accept in the same cycle as release).
//  - Latency: out_valid high exactly NCHUNK cycles after the accepting edge
//    (CHUNK==WIDTH -> 1 cycle). Throughput: one op per NCHUNK+2 cycles at best.
//  - overflow = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]), evaluated on final chunk.
//  - in_valid, a, b, cin, op_sub ignored outside IDLE; out_ready ignored outside DONE.
//  - Backpressure: DONE held indefinitely while out_ready=0; no output change.
//  - Reset mid-RUN/DONE: operation discarded, all outputs to reset values immediately.
//  - sum/carry/overflow are registered; they are undefined to the consumer unless
//    out_valid=1, but must never glitch while out_valid=1.
// STRUCTURE
//  - Shared package addsub_pkg: FSM state encoding (IDLE/RUN/DONE localparams) and the
//    op encoding (OP_ADD=0, OP_SUB=1), reused by the ALU decode.
//  - Sub-module addsub_chunk: combinational CHUNK-bit ripple adder (a, b, cin -> sum, cout),
//    built from 1-bit full-adder cells; instantiated once, indexed by the counter.
//  - Counter width $clog2(NCHUNK) (min 1). Elaboration check: WIDTH % CHUNK == 0.
// TESTING (WIDTH=32, CHUNK=8 unless noted)
//  1. add a=FFFFFFFF b=00000001 cin=0 -> sum=00000000 carry=1 ovf=0; out_valid 4 cycles after accept.
//  2. add a=7FFFFFFF b=00000001 cin=0 -> sum=80000000 carry=0 ovf=1 (cross-chunk carry ripple).
//  3. sub a=5 b=7 cin=0 -> sum=FFFFFFFE carry=0 ovf=0; sub a=80000000 b=1 -> 7FFFFFFF carry=1 ovf=1.
//  4. out_ready=0 for 10 cycles in DONE, in_valid toggling -> outputs stable, in_ready=0, no accept.
//  5. rst_n low 2 cycles into RUN -> out_valid/in_ready/sum=0 at once; next op 1+2 -> 3 correct.
//  6. WIDTH=CHUNK=8: add 80+80 -> sum=00 carry=1 ovf=1, out_valid 1 cycle after accept.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the sequential add/subtract unit and the ALU decode.
//   state_e : FSM state encoding (IDLE / RUN / DONE)
//   OP_ADD  : op_sub value selecting a + b + cin
//   OP_SUB  : op_sub value selecting a - b - cin
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_seq_if.sv
// Handshake bundle for addsub_seq.
//   Request  : in_valid / in_ready, a, b, cin, op_sub
//   Response : out_valid / out_ready, sum, carry, overflow
//   master   : producer/consumer side (drives the request, accepts the response)
//   slave    : the arithmetic unit
interface addsub_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;

    modport master (
        output in_valid, a, b, cin, op_sub, out_ready,
        input  in_ready, out_valid, sum, carry, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, op_sub, out_ready,
        output in_ready, out_valid, sum, carry, overflow
    );
endinterface

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple-carry adder built from 1-bit full-adder cells.
//   a, b : CHUNK-bit addends
//   cin  : carry into bit 0
//   sum  : CHUNK-bit sum
//   cout : carry out of the top bit
module addsub_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);
    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[CHUNK];
endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle add/subtract unit: WIDTH-bit operands processed CHUNK bits per clock,
// carry held in a register between chunks. One operation in flight at a time.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : addsub_seq_if slave (request handshake in, result handshake out)
// Subtraction is a + ~b + ~cin, so the final carry is NOT borrow.
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    addsub_seq_if.slave bus
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    if ((CHUNK == 0) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $error("addsub_seq: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             c_q, ovf_q, in_ready_q;
    logic [CHUNK-1:0] a_ch, b_ch, s_ch;
    logic             c_out;
    logic [31:0]      base;
    logic             accept, last;

    assign accept = (state_q == IDLE) && in_ready_q && bus.in_valid;
    assign last   = (cnt_q == LAST);
    assign base   = 32'(cnt_q) * CHUNK;
    assign a_ch   = a_q[base +: CHUNK];
    assign b_ch   = b_q[base +: CHUNK];

    addsub_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a    (a_ch),
        .b    (b_ch),
        .cin  (c_q),
        .sum  (s_ch),
        .cout (c_out)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath. in_ready is registered so it stays low through reset and only
    // rises on the first edge after release (and the edge after a result is taken).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            c_q        <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            in_ready_q <= (state_d == IDLE);
            if (accept) begin
                a_q   <= bus.a;
                b_q   <= (bus.op_sub == OP_SUB) ? ~bus.b : bus.b;
                c_q   <= (bus.op_sub == OP_SUB) ? ~bus.cin : bus.cin;
                cnt_q <= '0;
            end else if (state_q == RUN) begin
                sum_q[base +: CHUNK] <= s_ch;
                c_q                  <= c_out;
                cnt_q                <= last ? '0 : cnt_q + 1'b1;
                if (last) begin
                    // Same-sign operands whose result flips sign
                    ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_ch[CHUNK-1] != a_q[WIDTH-1]);
                end
            end
        end
    end

    // Outputs
    always_comb begin
        bus.in_ready  = in_ready_q;
        bus.out_valid = (state_q == DONE);
        bus.sum       = sum_q;
        bus.carry     = c_q;
        bus.overflow  = ovf_q;
    end
endmodule

// File: tb/tb_addsub_seq.sv
module tb_addsub_seq;
    localparam int NCH = 4;

    typedef struct packed {
        logic [31:0] sum;
        logic        carry;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    addsub_seq_if #(.WIDTH(32)) bus ();
    addsub_seq_if #(.WIDTH(8))  bus8 ();

    addsub_seq #(.WIDTH(32), .CHUNK(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    addsub_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic res_t model(input int w, input longint a, input longint b,
                                   input bit cin, input bit sub);
        longint mod, half, sa, sb, r, u;
        res_t   res;
        mod  = longint'(1) << w;
        half = mod / 2;
        sa   = (a >= half) ? a - mod : a;
        sb   = (b >= half) ? b - mod : b;
        if (!sub) begin
            u         = a + b + longint'(cin);
            r         = sa + sb + longint'(cin);
            res.carry = (u >= mod);
        end else begin
            u         = a - b - longint'(cin);
            r         = sa - sb - longint'(cin);
            res.carry = (a >= b + longint'(cin));
        end
        u       = ((u % mod) + mod) % mod;
        res.sum = 32'(u);
        res.ovf = (r < -half) || (r >= half);
        return res;
    endfunction

    // Scoreboard fill/drain on handshakes of the 32-bit unit.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(32, longint'(bus.a), longint'(bus.b), bus.cin, bus.op_sub));
        end
    end

    // Compare every cycle a result is presented.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected out_valid", 64'(bus.out_valid), 64'd0);
            end else begin
                chk("model sum", 64'(bus.sum), 64'(exp_q[0].sum));
                chk("model carry", 64'(bus.carry), 64'(exp_q[0].carry));
                chk("model overflow", 64'(bus.overflow), 64'(exp_q[0].ovf));
            end
        end
    end

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic op, input logic [31:0] es,
                         input logic ec, input logic ev, input int hold);
        int lat;
        int waitc;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.cin = cin; bus.op_sub = op; bus.in_valid = 1'b1;
        waitc = 0;
        while (!bus.in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        chk({tag, " in_ready wait"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        // Scramble inputs after the accepting edge; they must be ignored.
        bus.in_valid = 1'b0; bus.a = ~a; bus.b = ~b; bus.op_sub = ~op; bus.cin = ~cin;
        lat = 0;
        @(negedge clk);
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(NCH));
        chk({tag, " sum"}, 64'(bus.sum), 64'(es));
        chk({tag, " carry"}, 64'(bus.carry), 64'(ec));
        chk({tag, " overflow"}, 64'(bus.overflow), 64'(ev));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.in_valid = i[0];
            chk({tag, " hold in_ready"}, 64'(bus.in_ready), 64'd0);
            chk({tag, " hold out_valid"}, 64'(bus.out_valid), 64'd1);
            chk({tag, " hold sum"}, 64'(bus.sum), 64'(es));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        chk({tag, " released out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, " in_ready after release"}, 64'(bus.in_ready), 64'd1);
    endtask

    task automatic do_op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic op, input logic [7:0] es,
                          input logic ec, input logic ev);
        @(negedge clk);
        chk({tag, " in_ready"}, 64'(bus8.in_ready), 64'd1);
        bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.op_sub = op; bus8.in_valid = 1'b1;
        @(posedge clk);
        #1 bus8.in_valid = 1'b0;
        @(negedge clk);
        chk({tag, " out_valid early"}, 64'(bus8.out_valid), 64'd0);
        @(negedge clk);
        chk({tag, " out_valid"}, 64'(bus8.out_valid), 64'd1);
        chk({tag, " sum"}, 64'(bus8.sum), 64'(es));
        chk({tag, " carry"}, 64'(bus8.carry), 64'(ec));
        chk({tag, " overflow"}, 64'(bus8.overflow), 64'(ev));
        bus8.out_ready = 1'b1;
        @(posedge clk);
        #1 bus8.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0;
        bus.cin = 1'b0; bus.op_sub = 1'b0;
        bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.a = '0; bus8.b = '0;
        bus8.cin = 1'b0; bus8.op_sub = 1'b0;

        // Reset state
        #12;
        chk("reset in_ready", 64'(bus.in_ready), 64'd0);
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset sum", 64'(bus.sum), 64'd0);
        chk("reset carry", 64'(bus.carry), 64'd0);
        chk("reset overflow", 64'(bus.overflow), 64'd0);
        chk("reset in_ready w8", 64'(bus8.in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("in_ready low until edge", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        chk("in_ready after reset edge", 64'(bus.in_ready), 64'd1);

        do_op("add wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0);
        do_op("add ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0);
        do_op("sub neg", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 0);
        do_op("sub ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 0);
        do_op("sub borrow-in", 32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1,
              1'b0, 0);
        do_op("backpressure", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0,
              1'b0, 10);

        // Reset two cycles into RUN
        @(negedge clk);
        bus.a = 32'h1234_5678; bus.b = 32'h1111_1111; bus.cin = 1'b0; bus.op_sub = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrun reset in_ready", 64'(bus.in_ready), 64'd0);
        chk("midrun reset sum", 64'(bus.sum), 64'd0);
        chk("midrun reset carry", 64'(bus.carry), 64'd0);
        chk("midrun reset overflow", 64'(bus.overflow), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post reset in_ready", 64'(bus.in_ready), 64'd0);
        do_op("after reset", 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0,
              1'b0, 0);

        // Single-chunk configuration
        do_op8("w8 add", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        do_op8("w8 sub", 8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
